// File: rtl/div_pkg.sv
// div_pkg: shared state encodings, iteration count and helpers for the sequential divider.
package div_pkg;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;
    localparam int DIV_ITERS = 32;
    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
    function automatic logic [31:0] div_mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? -v : v;
    endfunction
endpackage

// File: rtl/div_iter.sv
// div_iter: one combinational radix-2 restoring division step.
module div_iter (
    input  logic [32:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [32:0] rem_next,
    output logic [31:0] quo_next
);
    logic [33:0] trial;
    // 34 bits so the sign of the trial subtraction is exact for any 33-bit shifted remainder
    assign trial    = {rem, quo[31]} - {2'b00, divisor};
    assign rem_next = trial[33] ? {rem[31:0], quo[31]} : trial[32:0];
    assign quo_next = {quo[30:0], ~trial[33]};
endmodule

// File: rtl/div_seq.sv
// div_seq: 33-cycle iterative signed/unsigned 32-bit divider behind the div_enable/div_complete handshake.
module div_seq
    import div_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_enable,
    input  logic             div_sign,
    input  logic             div_mod,
    input  logic [DIV_W-1:0] div_src1,
    input  logic [DIV_W-1:0] div_src2,
    input  logic             div_accept,
    input  logic             div_flush,
    output logic             div_complete,
    output logic [DIV_W-1:0] div_result,
    output logic             div_busy
);
    div_state_e state, state_next;
    logic [32:0] rem, rem_next;
    logic [31:0] quo, quo_next, divisor;
    logic [4:0]  cnt;
    logic        q_neg, r_neg, mod_r, last, zero;

    assign last     = cnt == 5'(DIV_ITERS - 1);
    assign zero     = div_src2 == '0;
    assign div_busy = state != DIV_IDLE;

    div_iter u_iter (
        .rem     (rem),
        .quo     (quo),
        .divisor (divisor),
        .rem_next(rem_next),
        .quo_next(quo_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= DIV_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = DIV_IDLE;
        if (div_flush)               state_next = DIV_IDLE;
        else if (state == DIV_IDLE)  state_next = div_enable ? (zero ? DIV_DONE : DIV_BUSY) : DIV_IDLE;
        else if (state == DIV_BUSY)  state_next = last ? DIV_DONE : DIV_BUSY;
        else if (state == DIV_DONE)  state_next = div_accept ? DIV_IDLE : DIV_DONE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem          <= '0;
            quo          <= '0;
            divisor      <= '0;
            cnt          <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            mod_r        <= 1'b0;
            div_complete <= 1'b0;
            div_result   <= '0;
        end else if (div_flush) begin
            div_complete <= 1'b0;
        end else if (state == DIV_IDLE) begin
            if (div_enable) begin
                quo     <= div_mag(div_src1, div_sign);
                divisor <= div_mag(div_src2, div_sign);
                q_neg   <= div_sign & (div_src1[31] ^ div_src2[31]);
                r_neg   <= div_sign & div_src1[31];
                mod_r   <= div_mod;
                rem     <= '0;
                cnt     <= '0;
                if (zero) begin
                    div_result   <= div_mod ? div_src1 : DIV_ZERO_QUO;
                    div_complete <= 1'b1;
                end
            end
        end else if (state == DIV_BUSY) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 5'd1;
            if (last) begin
                div_result   <= mod_r ? (r_neg ? -rem_next[31:0] : rem_next[31:0])
                                      : (q_neg ? -quo_next : quo_next);
                div_complete <= 1'b1;
            end
        end else if (state == DIV_DONE && div_accept) begin
            div_complete <= 1'b0;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized and directed checks of div_seq against an arithmetic reference model.
module tb_div_seq;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div_enable = 1'b0;
    logic        div_sign = 1'b0;
    logic        div_mod = 1'b0;
    logic [31:0] div_src1 = '0;
    logic [31:0] div_src2 = '0;
    logic        div_accept = 1'b0;
    logic        div_flush = 1'b0;
    logic        div_complete;
    logic [31:0] div_result;
    logic        div_busy;
    int tests = 0;
    int fails = 0;

    div_seq #(.DIV_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .div_enable  (div_enable),
        .div_sign    (div_sign),
        .div_mod     (div_mod),
        .div_src1    (div_src1),
        .div_src2    (div_src2),
        .div_accept  (div_accept),
        .div_flush   (div_flush),
        .div_complete(div_complete),
        .div_result  (div_result),
        .div_busy    (div_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic m);
        longint sa, sb, q, r;
        if (b == 0) return m ? a : 32'hFFFF_FFFF;
        if (!s) return m ? a % b : a / b;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return m ? r[31:0] : q[31:0];
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input logic m,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        div_src1 = a; div_src2 = b; div_sign = s; div_mod = m; div_enable = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (!div_complete && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = div_result;
    endtask

    task automatic accept_div();
        @(negedge clk);
        div_accept = 1'b1; div_enable = 1'b0;
        @(posedge clk); #1;
        div_accept = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        tests++; if (div_complete !== 1'b0) begin fails++; $display("FAIL reset_complete got %b want 0", div_complete); end
        tests++; if (div_result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", div_result); end
        tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", div_busy); end
        @(negedge clk); resetn = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta[6] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb[6] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic        ts[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        tm[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] te[6] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_div(ta[i], tb[i], ts[i], tm[i], res, lat);
            tests++; if (res !== te[i]) begin fails++; $display("FAIL directed%0d_result got %h want %h", i, res, te[i]); end
            tests++; if (lat !== 33) begin fails++; $display("FAIL directed%0d_latency got %0d want 33", i, lat); end
            accept_div();
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] res;
        int lat;
        do_div(32'd5, 32'd0, 1'b0, 1'b0, res, lat);
        tests++; if (res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divzero_quo got %h want ffffffff", res); end
        tests++; if (lat !== 1) begin fails++; $display("FAIL divzero_latency got %0d want 1", lat); end
        accept_div();
        do_div(32'd5, 32'd0, 1'b1, 1'b1, res, lat);
        tests++; if (res !== 32'd5) begin fails++; $display("FAIL divzero_rem got %h want 5", res); end
        tests++; if (lat !== 1) begin fails++; $display("FAIL divzero_rem_latency got %0d want 1", lat); end
        accept_div();
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat;
        int seen;
        @(negedge clk);
        div_src1 = 32'd100; div_src2 = 32'd7; div_sign = 1'b0; div_mod = 1'b0; div_enable = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        div_flush = 1'b1; div_enable = 1'b0;
        @(posedge clk); #1;
        div_flush = 1'b0;
        tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL flush_busy got %b want 0", div_busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (div_complete) seen++;
            @(posedge clk); #1;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL flush_no_complete got %0d cycles want 0", seen); end
        do_div(32'd9, 32'd3, 1'b0, 1'b0, res, lat);
        tests++; if (res !== 32'd3) begin fails++; $display("FAIL after_flush_result got %h want 3", res); end
        tests++; if (lat !== 33) begin fails++; $display("FAIL after_flush_latency got %0d want 33", lat); end
        accept_div();
        @(negedge clk);
        div_src1 = 32'd77; div_src2 = 32'd5; div_enable = 1'b1;
        @(posedge clk);
        repeat (31) @(posedge clk);
        @(negedge clk);
        div_flush = 1'b1; div_enable = 1'b0;
        @(posedge clk); #1;
        div_flush = 1'b0;
        tests++; if (div_complete !== 1'b0) begin fails++; $display("FAIL flush_at_done_edge got %b want 0", div_complete); end
        tests++; if (div_busy !== 1'b0) begin fails++; $display("FAIL flush_at_done_busy got %b want 0", div_busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat;
        do_div(32'd100, 32'd7, 1'b0, 1'b0, res, lat);
        tests++; if (res !== 32'd14) begin fails++; $display("FAIL hold_first got %h want 14", res); end
        @(negedge clk);
        div_src1 = 32'd50; div_src2 = 32'd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++; if (div_complete !== 1'b1 || div_result !== 32'd14) begin
                fails++; $display("FAIL hold%0d got complete=%b result=%h want 1/14", i, div_complete, div_result);
            end
        end
        @(negedge clk);
        div_accept = 1'b1;
        @(posedge clk); #1;
        div_accept = 1'b0;
        tests++; if (div_busy !== 1'b0 || div_complete !== 1'b0) begin
            fails++; $display("FAIL accept_idle got busy=%b complete=%b want 0/0", div_busy, div_complete);
        end
        @(posedge clk); #1;
        lat = 1;
        while (!div_complete && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++; if (div_result !== 32'd10) begin fails++; $display("FAIL b2b_result got %h want 10", div_result); end
        tests++; if (lat !== 33) begin fails++; $display("FAIL b2b_latency got %0d want 33", lat); end
        accept_div();
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat;
        @(negedge clk);
        div_src1 = 32'd200; div_src2 = 32'd3; div_sign = 1'b0; div_mod = 1'b0; div_enable = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        #2;
        tests++; if (div_busy !== 1'b1) begin fails++; $display("FAIL pre_reset_busy got %b want 1", div_busy); end
        resetn = 1'b0;
        #1;
        tests++; if (div_busy !== 1'b0 || div_complete !== 1'b0 || div_result !== 32'd0) begin
            fails++; $display("FAIL async_reset got busy=%b complete=%b result=%h want 0/0/0", div_busy, div_complete, div_result);
        end
        div_enable = 1'b0;
        @(negedge clk); resetn = 1'b1;
        do_div(32'd64, 32'd8, 1'b0, 1'b0, res, lat);
        tests++; if (res !== 32'd8) begin fails++; $display("FAIL post_reset_result got %h want 8", res); end
        tests++; if (lat !== 33) begin fails++; $display("FAIL post_reset_latency got %0d want 33", lat); end
        accept_div();
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp;
        logic s, m;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = $urandom;
                3: b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            s = 1'($urandom_range(0, 1));
            m = 1'($urandom_range(0, 1));
            exp = ref_div(a, b, s, m);
            do_div(a, b, s, m, res, lat);
            tests++; if (res !== exp) begin
                fails++; $display("FAIL rand%0d_result %h/%h s=%b m=%b got %h want %h", i, a, b, s, m, res, exp);
            end
            tests++; if (lat !== ((b == 0) ? 1 : 33)) begin
                fails++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, (b == 0) ? 1 : 33);
            end
            accept_div();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
